axi4_mem_slave_param: RTL and testbench
=======================================

Name: axi4_mem_slave_param

Overview:
- Parametrised AXI4 memory-mapped slave with independent read and write channels.
- Backed by an internal word-addressed RAM of DEPTH words.
- Supports FIXED, INCR and WRAP bursts, byte strobes, SLVERR on illegal or out-of-range access, and full VALID/READY backpressure.
- Successor to the fixed-width single-mode slave; this is the DUT behind the existing write/read test modports.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 32, data width in bits; must be 32, 64 or 128.
- DEPTH, 1024, memory depth in DATA_W words; DEPTH*DATA_W/8 ≤ 2^ADDR_W.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESTN  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_W  write start byte address.
- AWLEN  in  8  beats minus 1.
- AWSIZE  in  3  log2 bytes per beat.
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
- AWVALID  in  1  / AWREADY  out  1.
- WDATA  in  DATA_W  / WSTRB  in  DATA_W/8  / WLAST  in  1.
- WVALID  in  1  / WREADY  out  1.
- BRESP  out  2  / BVALID  out  1  / BREADY  in  1.
- ARADDR  in  ADDR_W  / ARLEN  in  8  / ARSIZE  in  3  / ARBURST  in  2.
- ARVALID  in  1  / ARREADY  out  1.
- RDATA  out  DATA_W  / RRESP  out  2  / RLAST  out  1.
- RVALID  out  1  / RREADY  in  1.

Behaviour:
- Reset (ARESTN low, asynchronous) clears the following:
  - All READY/VALID outputs = 0.
  - BRESP = RRESP = 00; RDATA = 0; RLAST = 0.
  - Both FSMs go to IDLE.
  - Memory contents are not reset.
  - One cycle after ARESTN rises, AWREADY = ARREADY = 1.
- Reset mid-burst abandons the burst; no B/R response is issued for it.
- Write FSM states: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY = 1. On AW handshake, latch addr/len/size/burst and the error flag, then go to W_DATA.
  - W_DATA: WREADY = 1. On each W handshake, write lanes with WSTRB = 1 at the current word (only if no error) and advance the address.
  - After beat LEN+1, go to W_RESP. BVALID rises the cycle after the last W handshake.
  - WLAST is checked: asserted early, or absent on beat LEN+1, sets SLVERR. Beat count always follows AWLEN.
  - W_RESP: hold BVALID/BRESP until BREADY, then go to W_IDLE. A handshake in the same cycle BVALID rises is legal.
- Read FSM states: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY = 1.
  - First RVALID comes the cycle after the AR handshake. With RREADY held high, one beat per cycle.
  - RDATA, RRESP and RLAST are stable while RVALID && !RREADY.
  - RLAST = 1 on beat ARLEN+1 only. Return to R_IDLE after the RLAST handshake.
- Channels are fully concurrent. On a same-word read and write in the same cycle, the read returns pre-write data (read-first).
- Address generation (per beat, bytes = 2^SIZE):
  - FIXED: address constant.
  - INCR: addr += bytes.
  - WRAP: span = bytes*(LEN+1); addr = (addr & ~(span-1)) | ((addr+bytes) & (span-1)).
  - Word index = addr >> log2(DATA_W/8).
- SLVERR (10) is decided at the address handshake and applies to the whole burst. Conditions:
  - SIZE > log2(DATA_W/8);
  - WRAP with LEN not in {1,3,7,15};
  - WRAP with a start address not aligned to bytes;
  - burst reserved (11);
  - any beat word index ≥ DEPTH (INCR: start + span - 1 beyond memory; FIXED/WRAP: checked on the span).
- On SLVERR: writes are suppressed but all beats are still accepted; reads return RDATA = 0 with RRESP = 10 on every beat.
- Otherwise the response is OKAY (00). No EXOKAY.
- Narrow transfers: the master supplies lane-correct WSTRB. The slave writes only the strobed lanes; reads return the full word.

Decomposition:
- Package axi4_pkg contains:
  - burst_e enum (FIXED/INCR/WRAP/RSVD) and resp_e enum (OKAY/EXOKAY/SLVERR/DECERR);
  - write and read state enums;
  - function next_addr(addr, size, len, burst).
- One sub-module, axi4_burst_ctrl, holds the latched burst attributes, beat counter, next-address logic and error check. It is instantiated once for AW and once for AR.
- Memory is an inferred array in the top; no separate RAM module.

Test Plan:
- Reset, then INCR write AWADDR=0x10, LEN=3, SIZE=2, data 0xA0..0xA3, WSTRB=F → BRESP=00. INCR read of the same → RDATA A0,A1,A2,A3, RLAST on beat 4 only, RRESP=00.
- WRAP write AWADDR=0x38, LEN=3, SIZE=2 → beats go to 0x38, 0x3C, 0x30, 0x34. Readback confirms the values land at the wrapped words.
- Write with WSTRB=0011 of 0xDEADBEEF over 0x11223344 at 0x0 → read returns 0x1122BEEF.
- INCR read starting at the last word, LEN=1 (crosses DEPTH) → two beats, RDATA=0, RRESP=10 each. Write of the same → BRESP=10, memory unchanged.
- Read burst with RREADY toggled 1,0,0,1 → RDATA/RLAST held while stalled, no beat lost or duplicated. Early WLAST on beat 2 of LEN=3 → all 4 beats accepted, BRESP=10.
- Assert ARESTN=0 mid write burst → all outputs 0 immediately. After release AWREADY=1 and a new burst completes normally with BRESP=00.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared types and address-step helper for the AXI4 memory slave.
// Address arithmetic is done at a fixed 32-bit width so it serves any ADDR_W up to 32.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wstate_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  localparam int CALC_W = 32;

  function automatic logic [CALC_W-1:0] next_addr(
    input logic [CALC_W-1:0] addr,
    input logic [2:0]        size,
    input logic [7:0]        len,
    input burst_e            burst
  );
    logic [CALC_W-1:0] bytes;
    logic [CALC_W-1:0] mask;
    bytes = 32'd1 << size;
    mask  = (bytes * ({24'd0, len} + 32'd1)) - 32'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = addr + bytes;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + bytes) & mask);
      default:     next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi4_burst_ctrl.sv
// Per-channel burst tracker: latches the address-phase attributes, counts beats,
// steps the address and classifies the burst as legal or SLVERR.
module axi4_burst_ctrl
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [7:0]               in_len,
  input  logic [2:0]               in_size,
  input  logic [1:0]               in_burst,
  input  logic                     advance,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic [$clog2(DEPTH)-1:0] nidx,
  output logic                     err,
  output logic                     nerr,
  output logic                     last,
  output logic                     nlast
);

  localparam int WB    = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        len_r;
  logic [7:0]        cnt_r;
  logic [2:0]        size_r;
  burst_e            burst_r;
  logic              err_r;

  logic [CALC_W-1:0] in_addr_s;
  logic [CALC_W-1:0] bytes_s;
  logic [CALC_W-1:0] span_s;
  logic [CALC_W-1:0] mask_s;
  logic [CALC_W-1:0] hi_s;
  logic              size_bad_s;
  logic              wrap_len_bad_s;
  logic              wrap_align_bad_s;
  logic              rsvd_s;
  logic              range_bad_s;
  logic              chk_err_s;
  logic [ADDR_W-1:0] step_addr_s;

  // Classify the burst on the address channel; hi_s is the highest byte it can touch
  always_comb begin
    in_addr_s        = CALC_W'(in_addr);
    bytes_s          = 32'd1 << in_size;
    span_s           = bytes_s * (CALC_W'(in_len) + 32'd1);
    mask_s           = span_s - 32'd1;
    hi_s             = in_addr_s + bytes_s - 32'd1;
    wrap_len_bad_s   = 1'b0;
    wrap_align_bad_s = 1'b0;
    rsvd_s           = 1'b0;
    case (burst_e'(in_burst))
      BURST_FIXED: hi_s = in_addr_s + bytes_s - 32'd1;
      BURST_INCR:  hi_s = in_addr_s + span_s - 32'd1;
      BURST_WRAP: begin
        hi_s             = (in_addr_s & ~mask_s) + span_s - 32'd1;
        wrap_len_bad_s   = !(in_len inside {8'd1, 8'd3, 8'd7, 8'd15});
        wrap_align_bad_s = (in_addr_s & (bytes_s - 32'd1)) != 32'd0;
      end
      default: rsvd_s = 1'b1;
    endcase
    size_bad_s  = in_size > 3'(WB);
    range_bad_s = (hi_s >> WB) >= CALC_W'(DEPTH);
    chk_err_s   = size_bad_s | wrap_len_bad_s | wrap_align_bad_s | rsvd_s | range_bad_s;
  end

  assign step_addr_s = ADDR_W'(next_addr(CALC_W'(addr_r), size_r, len_r, burst_r));

  // Lookahead outputs let the read side fetch the next beat on the same edge it is accepted
  assign idx   = addr_r[WB +: IDX_W];
  assign nidx  = start ? in_addr[WB +: IDX_W] : step_addr_s[WB +: IDX_W];
  assign err   = err_r;
  assign nerr  = start ? chk_err_s : err_r;
  assign last  = (cnt_r == len_r);
  assign nlast = start ? (in_len == 8'd0) : ((cnt_r + 8'd1) == len_r);

  // Burst attribute latch and beat/address advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= {ADDR_W{1'b0}};
      len_r   <= 8'd0;
      cnt_r   <= 8'd0;
      size_r  <= 3'd0;
      burst_r <= BURST_FIXED;
      err_r   <= 1'b0;
    end else if (start) begin
      addr_r  <= in_addr;
      len_r   <= in_len;
      cnt_r   <= 8'd0;
      size_r  <= in_size;
      burst_r <= burst_e'(in_burst);
      err_r   <= chk_err_s;
    end else if (advance) begin
      addr_r  <= step_addr_s;
      cnt_r   <= cnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/axi4_mem_slave_param.sv
// AXI4 memory-mapped slave over an inferred RAM with independent read and write engines.
// All handshake and response outputs are registered; reads are read-first against writes.
module axi4_mem_slave_param
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                ACLK,
  input  logic                ARESTN,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int STRB_W = DATA_W/8;
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  wstate_e w_state_r, w_next_s;
  rstate_e r_state_r, r_next_s;

  logic              awready_r, wready_r, bvalid_r, wlast_err_r;
  logic [1:0]        bresp_r;
  logic              arready_r, rvalid_r, rlast_r;
  logic [1:0]        rresp_r;
  logic [DATA_W-1:0] rdata_r;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, wlast_bad_s, r_load_s;

  logic [IDX_W-1:0] w_idx_s, w_nidx_s, r_idx_s, r_nidx_s;
  logic             w_err_s, w_nerr_s, w_last_s, w_nlast_s;
  logic             r_err_s, r_nerr_s, r_last_s, r_nlast_s;
  logic             unused_ok_s;

  assign AWREADY = awready_r;
  assign WREADY  = wready_r;
  assign BVALID  = bvalid_r;
  assign BRESP   = bresp_r;
  assign ARREADY = arready_r;
  assign RVALID  = rvalid_r;
  assign RDATA   = rdata_r;
  assign RRESP   = rresp_r;
  assign RLAST   = rlast_r;

  assign aw_hs_s     = AWVALID && awready_r;
  assign w_hs_s      = WVALID && wready_r;
  assign b_hs_s      = bvalid_r && BREADY;
  assign ar_hs_s     = ARVALID && arready_r;
  assign r_hs_s      = rvalid_r && RREADY;
  assign wlast_bad_s = w_hs_s && (WLAST != w_last_s);
  assign r_load_s    = ar_hs_s || (r_hs_s && !rlast_r);

  assign unused_ok_s = ^{w_nidx_s, w_nerr_s, w_nlast_s, r_idx_s, r_err_s, r_last_s};

  axi4_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_aw_ctrl (
    .clk      (ACLK),
    .rst_n    (ARESTN),
    .start    (aw_hs_s),
    .in_addr  (AWADDR),
    .in_len   (AWLEN),
    .in_size  (AWSIZE),
    .in_burst (AWBURST),
    .advance  (w_hs_s),
    .idx      (w_idx_s),
    .nidx     (w_nidx_s),
    .err      (w_err_s),
    .nerr     (w_nerr_s),
    .last     (w_last_s),
    .nlast    (w_nlast_s)
  );

  axi4_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ar_ctrl (
    .clk      (ACLK),
    .rst_n    (ARESTN),
    .start    (ar_hs_s),
    .in_addr  (ARADDR),
    .in_len   (ARLEN),
    .in_size  (ARSIZE),
    .in_burst (ARBURST),
    .advance  (r_hs_s),
    .idx      (r_idx_s),
    .nidx     (r_nidx_s),
    .err      (r_err_s),
    .nerr     (r_nerr_s),
    .last     (r_last_s),
    .nlast    (r_nlast_s)
  );

  // Write FSM state register
  always_ff @(posedge ACLK or negedge ARESTN) begin
    if (!ARESTN) w_state_r <= W_IDLE;
    else         w_state_r <= w_next_s;
  end

  // Write FSM next state; beat count comes from AWLEN, never from WLAST
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
      W_DATA:  if (w_hs_s && w_last_s) w_next_s = W_RESP; else w_next_s = W_DATA;
      W_RESP:  if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write channel registered outputs and WLAST protocol tracking
  always_ff @(posedge ACLK or negedge ARESTN) begin
    if (!ARESTN) begin
      awready_r   <= 1'b0;
      wready_r    <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= RESP_OKAY;
      wlast_err_r <= 1'b0;
    end else begin
      awready_r <= (w_next_s == W_IDLE);
      wready_r  <= (w_next_s == W_DATA);
      bvalid_r  <= (w_next_s == W_RESP);
      if (aw_hs_s)          wlast_err_r <= 1'b0;
      else if (wlast_bad_s) wlast_err_r <= 1'b1;
      if (w_hs_s && w_last_s)
        bresp_r <= (w_err_s || wlast_err_r || wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Strobed byte-lane writes; RAM contents survive reset
  always_ff @(posedge ACLK) begin
    if (w_hs_s && !w_err_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (WSTRB[i]) mem[w_idx_s][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK or negedge ARESTN) begin
    if (!ARESTN) r_state_r <= R_IDLE;
    else         r_state_r <= r_next_s;
  end

  // Read FSM next state
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
      R_DATA:  if (r_hs_s && rlast_r) r_next_s = R_IDLE; else r_next_s = R_DATA;
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read beat register: loads only on AR accept or a non-final R accept, so it holds under stall
  always_ff @(posedge ACLK or negedge ARESTN) begin
    if (!ARESTN) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      rresp_r   <= RESP_OKAY;
      rlast_r   <= 1'b0;
    end else begin
      arready_r <= (r_next_s == R_IDLE);
      rvalid_r  <= (r_next_s == R_DATA);
      if (r_load_s) begin
        rdata_r <= r_nerr_s ? {DATA_W{1'b0}} : mem[r_nidx_s];
        rresp_r <= r_nerr_s ? RESP_SLVERR : RESP_OKAY;
        rlast_r <= r_nlast_s;
      end else if (r_hs_s) begin
        rlast_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_slave_param.sv
// Directed bench for axi4_mem_slave_param: bursts, strobes, SLVERR, backpressure, mid-burst reset.
module tb_axi4_mem_slave_param;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  logic              ACLK, ARESTN;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [7:0]        AWLEN, ARLEN;
  logic [2:0]        AWSIZE, ARSIZE;
  logic [1:0]        AWBURST, ARBURST;
  logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [3:0]        WSTRB;
  logic [1:0]        BRESP, RRESP;
  logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wd      [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          rd_n;
  logic [1:0]  bresp_got;

  axi4_mem_slave_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESTN(ARESTN),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] strb, input int last_at,
                          output logic [1:0] resp);
    int guard;
    AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    guard = 0;
    while (!AWREADY && guard < 100) begin tick(); guard++; end
    if (!AWREADY) check("aw_timeout", 64'd0, 64'd1);
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wd[i]; WSTRB = strb; WLAST = (i == last_at); WVALID = 1'b1;
      guard = 0;
      while (!WREADY && guard < 100) begin tick(); guard++; end
      if (!WREADY) check("w_timeout", 64'd0, 64'd1);
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    guard = 0;
    while (!BVALID && guard < 100) begin tick(); guard++; end
    if (!BVALID) check("b_timeout", 64'd0, 64'd1);
    resp = BRESP;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [15:0] pat, input int pat_len);
    int          guard;
    int          cyc;
    logic        held_v;
    logic [31:0] held_d;
    logic        held_l;
    ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    guard = 0;
    while (!ARREADY && guard < 100) begin tick(); guard++; end
    if (!ARREADY) check("ar_timeout", 64'd0, 64'd1);
    tick();
    ARVALID = 1'b0;
    rd_n = 0; cyc = 0; held_v = 1'b0; held_d = 32'd0; held_l = 1'b0;
    while (rd_n <= int'(len) && cyc < 200) begin
      RREADY = (cyc < pat_len) ? pat[cyc] : 1'b1;
      if (held_v) begin
        check("r_hold_data", RDATA, held_d);
        check("r_hold_last", RLAST, held_l);
      end
      if (RVALID && RREADY) begin
        rd_data[rd_n] = RDATA; rd_resp[rd_n] = RRESP; rd_last[rd_n] = RLAST;
        rd_n++;
        held_v = 1'b0;
      end else if (RVALID) begin
        held_v = 1'b1; held_d = RDATA; held_l = RLAST;
      end else begin
        held_v = 1'b0;
      end
      tick();
      cyc++;
    end
    RREADY = 1'b0;
    if (rd_n != int'(len) + 1) check("r_beat_count", 64'(rd_n), 64'(int'(len) + 1));
    check("r_no_extra_beat", RVALID, 64'd0);
  endtask

  initial begin
    ARESTN = 1'b0;
    AWADDR = '0; AWLEN = 8'd0; AWSIZE = 3'd0; AWBURST = 2'd0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = 8'd0; ARSIZE = 3'd0; ARBURST = 2'd0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", AWREADY, 64'd0);
    check("rst_arready", ARREADY, 64'd0);
    check("rst_valids", {WREADY, BVALID, RVALID, RLAST}, 64'd0);
    check("rst_resp_data", {BRESP, RRESP, RDATA}, 64'd0);
    ARESTN = 1'b1;
    tick();
    check("post_rst_awready", AWREADY, 64'd1);
    check("post_rst_arready", ARREADY, 64'd1);

    // INCR write and readback
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    do_write(16'h0010, 8'd3, 3'd2, 2'b01, 4'hF, 3, bresp_got);
    check("incr_bresp", bresp_got, 64'd0);
    do_read(16'h0010, 8'd3, 3'd2, 2'b01, 16'hFFFF, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_rdata%0d", i), rd_data[i], 64'(32'hA0 + 32'(i)));
      check($sformatf("incr_rresp%0d", i), rd_resp[i], 64'd0);
      check($sformatf("incr_rlast%0d", i), rd_last[i], 64'(i == 3));
    end

    // WRAP write at 0x38: beats land at 0x38, 0x3C, 0x30, 0x34
    for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + 32'(i);
    do_write(16'h0038, 8'd3, 3'd2, 2'b10, 4'hF, 3, bresp_got);
    check("wrap_bresp", bresp_got, 64'd0);
    do_read(16'h0030, 8'd3, 3'd2, 2'b01, 16'hFFFF, 0);
    check("wrap_word30", rd_data[0], 64'h000000B2);
    check("wrap_word34", rd_data[1], 64'h000000B3);
    check("wrap_word38", rd_data[2], 64'h000000B0);
    check("wrap_word3c", rd_data[3], 64'h000000B1);
    do_read(16'h0038, 8'd3, 3'd2, 2'b10, 16'hFFFF, 0);
    check("wrap_rd_beat0", rd_data[0], 64'h000000B0);
    check("wrap_rd_beat2", rd_data[2], 64'h000000B2);
    check("wrap_rd_last", {rd_last[2], rd_last[3]}, 64'd1);

    // Byte strobes
    wd[0] = 32'h11223344;
    do_write(16'h0000, 8'd0, 3'd2, 2'b01, 4'hF, 0, bresp_got);
    wd[0] = 32'hDEADBEEF;
    do_write(16'h0000, 8'd0, 3'd2, 2'b01, 4'h3, 0, bresp_got);
    check("strb_bresp", bresp_got, 64'd0);
    do_read(16'h0000, 8'd0, 3'd2, 2'b01, 16'hFFFF, 0);
    check("strb_rdata", rd_data[0], 64'h1122BEEF);
    check("strb_rlast", rd_last[0], 64'd1);

    // Out-of-range INCR burst from the last word
    wd[0] = 32'hCAFEF00D;
    do_write(16'h0FFC, 8'd0, 3'd2, 2'b01, 4'hF, 0, bresp_got);
    check("last_word_bresp", bresp_got, 64'd0);
    do_read(16'h0FFC, 8'd1, 3'd2, 2'b01, 16'hFFFF, 0);
    check("oor_rdata0", rd_data[0], 64'd0);
    check("oor_rdata1", rd_data[1], 64'd0);
    check("oor_rresp0", rd_resp[0], 64'd2);
    check("oor_rresp1", rd_resp[1], 64'd2);
    check("oor_rlast", {rd_last[0], rd_last[1]}, 64'd1);
    wd[0] = 32'h55; wd[1] = 32'h66;
    do_write(16'h0FFC, 8'd1, 3'd2, 2'b01, 4'hF, 1, bresp_got);
    check("oor_bresp", bresp_got, 64'd2);
    do_read(16'h0FFC, 8'd0, 3'd2, 2'b01, 16'hFFFF, 0);
    check("oor_mem_kept", rd_data[0], 64'hCAFEF00D);
    check("oor_kept_rresp", rd_resp[0], 64'd0);
    do_read(16'h0000, 8'd0, 3'd2, 2'b01, 16'hFFFF, 0);
    check("oor_no_alias", rd_data[0], 64'h1122BEEF);

    // Illegal WRAP length
    do_read(16'h0040, 8'd2, 3'd2, 2'b10, 16'hFFFF, 0);
    check("wrap_len_rresp", rd_resp[1], 64'd2);

    // RREADY backpressure 1,0,0,1
    do_read(16'h0010, 8'd3, 3'd2, 2'b01, 16'h0009, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_rdata%0d", i), rd_data[i], 64'(32'hA0 + 32'(i)));
      check($sformatf("stall_rlast%0d", i), rd_last[i], 64'(i == 3));
    end

    // Early WLAST on beat 2 of a 4-beat burst
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + 32'(i);
    do_write(16'h0040, 8'd3, 3'd2, 2'b01, 4'hF, 1, bresp_got);
    check("early_wlast_bresp", bresp_got, 64'd2);
    check("aw_ready_after_b", AWREADY, 64'd1);

    // Reset in the middle of a write burst
    for (int i = 0; i < 4; i++) wd[i] = 32'hE0 + 32'(i);
    AWADDR = 16'h0080; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    WDATA = wd[0]; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    tick();
    WDATA = wd[1];
    tick();
    ARESTN = 1'b0;
    #1;
    check("midrst_ready", {AWREADY, WREADY, ARREADY}, 64'd0);
    check("midrst_valid", {BVALID, RVALID, RLAST}, 64'd0);
    WVALID = 1'b0;
    tick();
    ARESTN = 1'b1;
    tick();
    check("midrst_awready", AWREADY, 64'd1);
    check("midrst_no_b", {BVALID, WREADY}, 64'd0);
    wd[0] = 32'hD0; wd[1] = 32'hD1;
    do_write(16'h0080, 8'd1, 3'd2, 2'b01, 4'hF, 1, bresp_got);
    check("midrst_new_bresp", bresp_got, 64'd0);
    do_read(16'h0080, 8'd1, 3'd2, 2'b01, 16'hFFFF, 0);
    check("midrst_rdata0", rd_data[0], 64'h000000D0);
    check("midrst_rdata1", rd_data[1], 64'h000000D1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
